// File: rtl/mem_request_unit_if.sv
// rtl/mem_request_unit_if.sv - control-unit/memory handshake bundle for mem_request_unit
// master = the request unit; slave = the control unit, datapath and memory side.
interface mem_request_unit_if #(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             MemRead;
  logic             MemWrite;
  logic             mem_halt;
  logic             imemREN;
  logic             dmemREN;
  logic             dmemWEN;
  logic             pc_en;
  logic             halt;
  logic             err;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  ihit, dhit, MemRead, MemWrite, mem_halt,
    output imemREN, dmemREN, dmemWEN, pc_en, halt, err, instr_cnt
  );

  modport slave (
    output ihit, dhit, MemRead, MemWrite, mem_halt,
    input  imemREN, dmemREN, dmemWEN, pc_en, halt, err, instr_cnt
  );
endinterface

// File: rtl/mem_request_unit.sv
// rtl/mem_request_unit.sv - fetch/data request sequencer with PC gating, halt latch and watchdog
// Issues one instruction fetch or one data access at a time and commits on the matching hit.
module mem_request_unit #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  mem_request_unit_if.master  bus
);

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int WD_W  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DATA   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t           state;
  logic [WD_W-1:0]  wd;
  logic [CNT_W-1:0] cnt;
  logic             imem_ren_q;
  logic             dmem_ren_q;
  logic             dmem_wen_q;
  logic             halt_q;
  logic             err_q;
  logic             timeout;
  logic             fetch_commit;
  logic             data_commit;
  logic             pc_en;

  // wd holds the number of the DATA cycle currently in progress, so the
  // last permitted cycle is the one where it equals TIMEOUT_CYCLES.
  assign timeout      = WD_EN && (state == DATA) && (wd == WD_MAX);
  assign fetch_commit = (state == FETCH) && bus.ihit && !bus.mem_halt &&
                        !bus.MemRead && !bus.MemWrite;
  assign data_commit  = (state == DATA) && bus.dhit && !timeout;
  assign pc_en        = fetch_commit || data_commit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      wd         <= '0;
      cnt        <= '0;
      imem_ren_q <= 1'b0;
      dmem_ren_q <= 1'b0;
      dmem_wen_q <= 1'b0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (pc_en && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          imem_ren_q <= 1'b1;
          state      <= FETCH;
        end

        FETCH: begin
          if (bus.ihit) begin
            if (bus.mem_halt) begin
              imem_ren_q <= 1'b0;
              halt_q     <= 1'b1;
              state      <= HALTED;
            end else if (bus.MemWrite) begin
              imem_ren_q <= 1'b0;
              dmem_wen_q <= 1'b1;
              dmem_ren_q <= 1'b0;
              wd         <= WD_W'(1);
              state      <= DATA;
            end else if (bus.MemRead) begin
              imem_ren_q <= 1'b0;
              dmem_ren_q <= 1'b1;
              dmem_wen_q <= 1'b0;
              wd         <= WD_W'(1);
              state      <= DATA;
            end
          end
        end

        DATA: begin
          // Timeout is tested first so a hit landing on the final cycle is discarded.
          if (timeout) begin
            dmem_ren_q <= 1'b0;
            dmem_wen_q <= 1'b0;
            err_q      <= 1'b1;
            halt_q     <= 1'b1;
            wd         <= '0;
            state      <= HALTED;
          end else if (bus.dhit) begin
            dmem_ren_q <= 1'b0;
            dmem_wen_q <= 1'b0;
            imem_ren_q <= 1'b1;
            wd         <= '0;
            state      <= FETCH;
          end else if (WD_EN) begin
            wd <= wd + WD_W'(1);
          end
        end

        HALTED: begin
          imem_ren_q <= 1'b0;
          dmem_ren_q <= 1'b0;
          dmem_wen_q <= 1'b0;
          halt_q     <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.imemREN   = imem_ren_q;
  assign bus.dmemREN   = dmem_ren_q;
  assign bus.dmemWEN   = dmem_wen_q;
  assign bus.pc_en     = pc_en;
  assign bus.halt      = halt_q;
  assign bus.err       = err_q;
  assign bus.instr_cnt = cnt;

endmodule

// File: tb/tb_mem_request_unit.sv
// tb/tb_mem_request_unit.sv - directed and randomized instruction-level bench for mem_request_unit
// Expected outputs come from per-instruction expectations plus a saturating commit count.
module tb_mem_request_unit;

  localparam int TMO   = 8;
  localparam int CW    = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic CLK;
  logic nRST;

  mem_request_unit_if #(.CNT_W(CW)) bus ();

  mem_request_unit #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CW)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int vectors;
  int miscompares;
  int exp_cnt;
  bit exp_halt;
  bit exp_err;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(string tag, bit imem, bit dr, bit dw, bit pc);
    chk({tag, ".imemREN"},   32'(bus.imemREN),   32'(imem));
    chk({tag, ".dmemREN"},   32'(bus.dmemREN),   32'(dr));
    chk({tag, ".dmemWEN"},   32'(bus.dmemWEN),   32'(dw));
    chk({tag, ".pc_en"},     32'(bus.pc_en),     32'(pc));
    chk({tag, ".halt"},      32'(bus.halt),      32'(exp_halt));
    chk({tag, ".err"},       32'(bus.err),       32'(exp_err));
    chk({tag, ".instr_cnt"}, 32'(bus.instr_cnt), 32'(exp_cnt));
  endtask

  task automatic drive(bit ih, bit dh, bit mr, bit mw, bit mh);
    bus.ihit     = ih;
    bus.dhit     = dh;
    bus.MemRead  = mr;
    bus.MemWrite = mw;
    bus.mem_halt = mh;
  endtask

  // One clock: inputs already driven, check mid-cycle, then advance to the next negedge.
  task automatic cyc(string tag, bit imem, bit dr, bit dw, bit pc);
    #1;
    expect_out(tag, imem, dr, dw, pc);
    @(negedge CLK);
    if (pc && exp_cnt < CNT_MAX) exp_cnt++;
  endtask

  task automatic model_reset();
    exp_cnt  = 0;
    exp_halt = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    model_reset();
    drive(rb(), rb(), rb(), rb(), rb());
    cyc("reset0", 0, 0, 0, 0);
    drive(rb(), rb(), rb(), rb(), rb());
    cyc("reset1", 0, 0, 0, 0);
    nRST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("idle", 0, 0, 0, 0);
  endtask

  task automatic fetch_wait(int pre);
    for (int i = 0; i < pre; i++) begin
      drive(1'b0, rb(), rb(), rb(), rb());
      cyc("fetch_wait", 1, 0, 0, 0);
    end
  endtask

  task automatic do_alu(int pre);
    fetch_wait(pre);
    drive(1'b1, rb(), 1'b0, 1'b0, 1'b0);
    cyc("alu", 1, 0, 0, 1);
  endtask

  // n = number of DATA cycles without dhit before the hit (n < TMO-1)
  task automatic do_mem(int pre, bit mr, bit mw, int n);
    bit is_w;
    is_w = mw;
    fetch_wait(pre);
    drive(1'b1, rb(), mr, mw, 1'b0);
    cyc("mem_issue", 1, 0, 0, 0);
    for (int i = 0; i <= n; i++) begin
      drive(rb(), (i == n), rb(), rb(), rb());
      cyc("mem_data", 0, !is_w, is_w, (i == n));
    end
  endtask

  task automatic do_timeout(bit late_dhit);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("tmo_issue", 1, 0, 0, 0);
    for (int i = 0; i < TMO; i++) begin
      drive(rb(), late_dhit && (i == TMO - 1), 1'b0, 1'b0, 1'b0);
      cyc("tmo_data", 0, 0, 1, 0);
    end
    exp_halt = 1'b1;
    exp_err  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(rb(), rb(), rb(), rb(), rb());
      cyc("tmo_after", 0, 0, 0, 0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nRST        = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);

    // reset state and first fetch
    apply_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("first_fetch", 1, 0, 0, 0);

    // single ALU op: count 0 -> 1
    do_alu(0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("after_alu", 1, 0, 0, 0);

    // LW with dhit on the third DATA cycle
    do_mem(0, 1'b1, 1'b0, 2);
    // SW with both MemRead and MemWrite: write wins
    do_mem(1, 1'b1, 1'b1, 0);

    // random instruction mix, long enough to saturate the counter
    for (int k = 0; k < 40; k++) begin
      int kind;
      int pre;
      bit mr;
      bit mw;
      kind = $urandom_range(0, 2);
      pre  = $urandom_range(0, 2);
      if (kind == 0) begin
        do_alu(pre);
      end else begin
        mr = rb();
        mw = mr ? rb() : 1'b1;
        do_mem(pre, mr, mw, $urandom_range(0, TMO - 2));
      end
    end
    do_alu(0);

    // watchdog: no dhit for TMO DATA cycles
    do_timeout(1'b0);

    // watchdog wins over dhit arriving on the last allowed cycle
    apply_reset();
    do_alu(1);
    do_timeout(1'b1);

    // HALT has priority over MemRead; halted unit ignores everything
    apply_reset();
    do_alu(0);
    drive(1'b1, rb(), 1'b1, rb(), 1'b1);
    cyc("halt_issue", 1, 0, 0, 0);
    exp_halt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(rb(), rb(), rb(), rb(), rb());
      cyc("halted", 0, 0, 0, 0);
    end

    // asynchronous reset in the middle of a store
    apply_reset();
    do_alu(0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mid_issue", 1, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    expect_out("mid_pre", 0, 0, 1, 0);
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    expect_out("mid_async", 0, 0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;
    cyc("mid_idle", 0, 0, 0, 0);
    cyc("mid_fetch", 1, 0, 0, 0);
    do_alu(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
